// File: rtl/pc_sequencer.sv
// Program-counter sequencer: selects the next fetch PC from sequential, branch,
// register-indirect and return-address-stack sources, with a circular return stack.
module pc_sequencer #(
    parameter int              PC_W      = 16,
    parameter int              COND_W    = 8,
    parameter int              UNCOND_W  = 11,
    parameter int              RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [1:0]                   branch_type,
    input  logic                         br_taken,
    input  logic [COND_W-1:0]            cond_offset,
    input  logic [UNCOND_W-1:0]          uncond_offset,
    input  logic [PC_W-1:0]              reg_target,
    input  logic                         call,
    input  logic                         ret,
    output logic [PC_W-1:0]              pc_out,
    output logic [PC_W-1:0]              link_pc,
    output logic                         redirect,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_overflow,
    output logic                         ras_underflow
);

    localparam int              PTR_W = $clog2(RAS_DEPTH);
    localparam int              CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    logic [PC_W-1:0]          pc_q, pc_d;
    logic [PC_W-1:0]          ras_q [RAS_DEPTH];
    logic [PTR_W-1:0]         sp_q, sp_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     ovf_q, ovf_d;
    logic                     unf_q, unf_d;
    logic                     ras_we;
    logic [PTR_W-1:0]         ras_waddr;
    logic [PTR_W-1:0]         top_idx;
    logic                     pop_ok;
    logic [PC_W-1:0]          seq_pc;
    logic signed [PC_W-1:0]   cond_ext;
    logic signed [PC_W-1:0]   uncond_ext;

    assign link_pc    = pc_q + PC_W'(1);
    assign cond_ext   = PC_W'(signed'(cond_offset));
    assign uncond_ext = PC_W'(signed'(uncond_offset));
    // sp_q points at the next free slot, so the top of stack sits one below it
    assign top_idx    = sp_q - PTR_W'(1);
    assign pop_ok     = ret && (cnt_q != '0);

    always_comb begin
        seq_pc = link_pc;
        case (branch_type)
            2'b11:   seq_pc = reg_target;
            2'b10:   seq_pc = pc_q + $unsigned(uncond_ext);
            2'b01:   seq_pc = br_taken ? (pc_q + $unsigned(cond_ext)) : link_pc;
            default: seq_pc = link_pc;
        endcase
        pc_d = pop_ok ? ras_q[top_idx] : seq_pc;
    end

    always_comb begin
        sp_d      = sp_q;
        cnt_d     = cnt_q;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
        ras_we    = 1'b0;
        ras_waddr = sp_q;
        if (pop_ok && call) begin
            // Call and return together: the popped top is replaced in place by the new link.
            ras_we    = 1'b1;
            ras_waddr = top_idx;
        end else if (pop_ok) begin
            sp_d  = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            unf_d = ret;
            if (call) begin
                ras_we = 1'b1;
                sp_d   = sp_q + PTR_W'(1);
                // A full stack wraps onto its oldest entry and keeps its count.
                if (cnt_q == FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            sp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (stall) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !stall && ras_we) begin
            ras_q[ras_waddr] <= link_pc;
        end
    end

    assign pc_out        = pc_q;
    assign ras_count     = cnt_q;
    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
    assign redirect      = !stall && (pc_d != link_pc);

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16, program-counter width in bits.
REQ-002 SHALL have parameter COND_W, default 8, conditional-branch offset width in bits.
REQ-003 SHALL have parameter UNCOND_W, default 11, unconditional-branch offset width in bits.
REQ-004 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, 2..16).
REQ-005 SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-006 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-007 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-008 SHALL have port stall, input, 1, hold all state when high.
REQ-009 SHALL have port branch_type, input, 2: 00 sequential, 01 conditional, 10 unconditional, 11 register-indirect.
REQ-010 SHALL have port br_taken, input, 1, condition outcome; used only when branch_type=01.
REQ-011 SHALL have port cond_offset, input, COND_W, signed two's-complement offset.
REQ-012 SHALL have port uncond_offset, input, UNCOND_W, signed two's-complement offset.
REQ-013 SHALL have port reg_target, input, PC_W, absolute target for register-indirect branch.
REQ-014 SHALL have port call, input, 1, push return address this cycle.
REQ-015 SHALL have port ret, input, 1, pop return address and jump to it.
REQ-016 SHALL have port pc_out, output, PC_W, current fetch PC (registered).
REQ-017 SHALL have port link_pc, output, PC_W, combinational pc_out+1.
REQ-018 SHALL have port redirect, output, 1, combinational; high when next PC is not pc_out+1 in a non-stall cycle.
REQ-019 SHALL have port ras_count, output, clog2(RAS_DEPTH)+1, registered count of valid stack entries.
REQ-020 SHALL have port ras_overflow, output, 1, registered one-cycle pulse.
REQ-021 SHALL have port ras_underflow, output, 1, registered one-cycle pulse.

Function
REQ-022 SHALL compute all PC arithmetic modulo 2^PC_W; offsets are sign-extended to PC_W and added to pc_out.
REQ-023 SHALL select next PC, ret having priority: ret with ras_count>0 -> stack top; otherwise 11 -> reg_target; 10 -> pc_out+sext(uncond_offset); 01 with br_taken -> pc_out+sext(cond_offset); else pc_out+1.
REQ-024 SHALL load the selected next PC into pc_out at each rising edge when stall=0 and reset=0 (one-cycle latency).
REQ-025 SHALL, when stall=1, hold pc_out, stack contents and ras_count, ignore call/ret, and clear both flag pulses.
REQ-026 SHALL, on call, push link_pc; when ras_count=RAS_DEPTH, overwrite the oldest entry (circular), keep ras_count at RAS_DEPTH, and pulse ras_overflow next cycle.
REQ-027 SHALL, on ret with ras_count=0, take the non-ret next-PC path, leave the stack unchanged, and pulse ras_underflow next cycle.
REQ-028 SHALL, on simultaneous call and ret with ras_count>0, jump to the popped top and replace that entry with link_pc; ras_count unchanged; no flag.
REQ-029 SHALL, on simultaneous call and ret with ras_count=0, push link_pc, pulse ras_underflow and not ras_overflow.
REQ-030 SHALL keep each flag high for exactly one cycle per event; flags are low otherwise.

Reset
REQ-031 SHALL, on a clock edge with reset=1, set pc_out=RESET_PC, ras_count=0, ras_overflow=0, ras_underflow=0, regardless of stall, call or ret.
REQ-032 SHALL treat a reset arriving mid-sequence as discarding all stack entries; stack storage contents need not be cleared.

Verification
REQ-033 SHALL cover: reset, then 3 cycles of branch_type=00 -> pc_out 0,1,2,3; link_pc always pc_out+1.
REQ-034 SHALL cover: pc_out=0x0010, branch_type=01, br_taken=1, cond_offset=0xFC -> pc_out=0x000C; with br_taken=0 -> 0x0011; redirect high only in the taken case.
REQ-035 SHALL cover: pc_out=0xFFFF, branch_type=00 -> pc_out=0x0000 (wrap); branch_type=10, uncond_offset=0x002 at 0xFFFF -> 0x0001.
REQ-036 SHALL cover: 5 calls at PCs 0x10,0x20,0x30,0x40,0x50 (RAS_DEPTH=4) -> ras_overflow pulses on 5th only; 4 rets return 0x51,0x41,0x31,0x21; 5th ret -> ras_underflow pulse, pc_out advances by 1.
REQ-037 SHALL cover: stall=1 for 3 cycles with branch_type=11, call=1 -> pc_out, ras_count unchanged; reset asserted with stall=1 -> pc_out=RESET_PC, ras_count=0.
REQ-038 SHALL cover: ras_count=2, call and ret together at pc_out=0x30 -> pc_out=old top, top entry=0x31, ras_count=2, no flag.
